ula_8_bits_structure: RTL and testbench

- 8-bit ALU (ULA) with five operations: add, subtract, AND, OR, NOT, selected by a 3-bit opcode.
- Result and carry/borrow are registered on the rising clock edge.
- Sits in the datapath as the arithmetic/logic unit between operand registers and the result bus.
- Built structurally: one shared ripple-carry adder serves both add and subtract.

---
 rtl/ula_pkg.sv | 16 +
 rtl/ula_adder_8.sv | 39 +++
 rtl/ula_8_bits_structure.sv | 103 ++++++++++
 tb/tb_ula_8_bits_structure.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// Shared opcode encoding, datapath width and reset constants for the 8-bit ULA.
package ula_pkg;

    localparam int ULA_WIDTH = 8;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_NOT = 3'b100
    } ula_op_t;

    localparam logic [ULA_WIDTH-1:0] ULA_S_RST = '0;

endpackage

// File: rtl/ula_adder_8.sv
// 8-bit ripple-carry adder assembled from 1-bit full-adder cells.
// The ULA routes both ADD and SUB through this single adder.
module ula_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module ula_adder_8
    import ula_pkg::*;
(
    input  logic [ULA_WIDTH-1:0] a,
    input  logic [ULA_WIDTH-1:0] b,
    input  logic                 cin,
    output logic [ULA_WIDTH-1:0] sum,
    output logic                 cout
);
    logic [ULA_WIDTH:0] w_c;

    assign w_c[0] = cin;

    // Carry chain: cell i consumes the carry from cell i-1.
    for (genvar i = 0; i < ULA_WIDTH; i++) begin : g_fa
        ula_full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (w_c[i]),
            .sum  (sum[i]),
            .cout (w_c[i+1])
        );
    end

    assign cout = w_c[ULA_WIDTH];
endmodule

// File: rtl/ula_8_bits_structure.sv
// Registered 8-bit ALU: ADD/SUB on a shared ripple adder, AND/OR/NOT, reserved ops give 0.
// Define ULA_FLAGS_EN to add registered zero (ZF) and signed-overflow (OVF) outputs.
module ula_8_bits_structure
    import ula_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 CIN,
    input  logic [ULA_WIDTH-1:0] A,
    input  logic [ULA_WIDTH-1:0] B,
    input  logic [2:0]           X,
    output logic [ULA_WIDTH-1:0] S,
    output logic                 COUT
`ifdef ULA_FLAGS_EN
   ,output logic                 ZF,
    output logic                 OVF
`endif
);
    logic                 w_is_sub;
    logic [ULA_WIDTH-1:0] w_add_b;
    logic                 w_add_cin;
    logic [ULA_WIDTH-1:0] w_add_sum;
    logic                 w_add_cout;
    logic [ULA_WIDTH-1:0] w_s_nxt;
    logic                 w_cout_nxt;
    logic [ULA_WIDTH-1:0] r_s;
    logic                 r_cout;

    // SUB is A + ~B + ~CIN, which equals A - B - CIN modulo 256.
    assign w_is_sub  = (X == OP_SUB);
    assign w_add_b   = w_is_sub ? ~B   : B;
    assign w_add_cin = w_is_sub ? ~CIN : CIN;

    ula_adder_8 u_adder (
        .a    (A),
        .b    (w_add_b),
        .cin  (w_add_cin),
        .sum  (w_add_sum),
        .cout (w_add_cout)
    );

    always_comb begin
        w_s_nxt    = ULA_S_RST;
        w_cout_nxt = 1'b0;
        case (X)
            OP_ADD: begin
                w_s_nxt    = w_add_sum;
                w_cout_nxt = w_add_cout;
            end
            OP_SUB: begin
                w_s_nxt    = w_add_sum;
                // No carry out of the complemented add means a borrow happened.
                w_cout_nxt = ~w_add_cout;
            end
            OP_AND:  w_s_nxt = A & B;
            OP_OR:   w_s_nxt = A | B;
            OP_NOT:  w_s_nxt = ~A;
            default: w_s_nxt = ULA_S_RST;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_s    <= ULA_S_RST;
            r_cout <= 1'b0;
        end else begin
            r_s    <= w_s_nxt;
            r_cout <= w_cout_nxt;
        end
    end

    assign S    = r_s;
    assign COUT = r_cout;

`ifdef ULA_FLAGS_EN
    logic w_ovf_nxt;
    logic r_zf;
    logic r_ovf;

    always_comb begin
        w_ovf_nxt = 1'b0;
        case (X)
            OP_ADD:  w_ovf_nxt = (A[7] == B[7]) && (w_add_sum[7] != A[7]);
            OP_SUB:  w_ovf_nxt = (A[7] != B[7]) && (w_add_sum[7] != A[7]);
            default: w_ovf_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_zf  <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            r_zf  <= (w_s_nxt == '0);
            r_ovf <= w_ovf_nxt;
        end
    end

    assign ZF  = r_zf;
    assign OVF = r_ovf;
`endif

endmodule

// File: tb/tb_ula_8_bits_structure.sv
// Scoreboard bench for ula_8_bits_structure: driver queues arithmetic-model results,
// monitor pops one per clock edge and compares against the registered outputs.
module tb_ula_8_bits_structure;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       CIN;
    logic [7:0] A;
    logic [7:0] B;
    logic [2:0] X;
    logic [7:0] S;
    logic       COUT;
`ifdef ULA_FLAGS_EN
    logic       ZF;
    logic       OVF;
`endif

    ula_8_bits_structure dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .CIN   (CIN),
        .A     (A),
        .B     (B),
        .X     (X),
        .S     (S),
        .COUT  (COUT)
`ifdef ULA_FLAGS_EN
       ,.ZF    (ZF),
        .OVF   (OVF)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string      tag;
        logic [7:0] s;
        logic       cout;
        logic       zf;
        logic       ovf;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model from the arithmetic definitions, using plain integers.
    function automatic exp_t model(input string tag, input logic rst, input logic cin,
                                   input logic [7:0] a, input logic [7:0] b, input logic [2:0] x);
        exp_t e;
        int   r;
        int   sa;
        int   sb;
        e.tag = tag; e.s = 8'h00; e.cout = 1'b0; e.zf = 1'b0; e.ovf = 1'b0;
        if (!rst) return e;
        sa = (a >= 128) ? int'(a) - 256 : int'(a);
        sb = (b >= 128) ? int'(b) - 256 : int'(b);
        case (x)
            3'd0: begin
                r = int'(a) + int'(b) + int'(cin);
                e.s = 8'(r % 256); e.cout = (r > 255);
                r = sa + sb + int'(cin);
                e.ovf = (r > 127) || (r < -128);
            end
            3'd1: begin
                r = int'(a) - int'(b) - int'(cin);
                e.s = 8'((r + 512) % 256); e.cout = (r < 0);
                r = sa - sb - int'(cin);
                e.ovf = (r > 127) || (r < -128);
            end
            3'd2: e.s = a & b;
            3'd3: e.s = a | b;
            3'd4: e.s = ~a;
            default: e.s = 8'h00;
        endcase
        e.zf = (e.s == 8'h00);
        return e;
    endfunction

    task automatic drive(input string tag, input logic rst, input logic cin,
                         input logic [7:0] a, input logic [7:0] b, input logic [2:0] x);
        @(negedge CLK);
        RST_N = rst; CIN = cin; A = a; B = b; X = x;
        q.push_back(model(tag, rst, cin, a, b, x));
    endtask

    // Monitor: every edge produces a result; compare it to the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (S !== e.s || COUT !== e.cout) begin
                    errors++;
                    $display("FAIL %s: got S=%h COUT=%b, expected S=%h COUT=%b",
                             e.tag, S, COUT, e.s, e.cout);
                end
`ifdef ULA_FLAGS_EN
                checks++;
                if (ZF !== e.zf || OVF !== e.ovf) begin
                    errors++;
                    $display("FAIL %s_flags: got ZF=%b OVF=%b, expected ZF=%b OVF=%b",
                             e.tag, ZF, OVF, e.zf, e.ovf);
                end
`endif
            end
        end
    end

    initial begin
        RST_N = 1'b0; CIN = 1'b0; A = 8'h00; B = 8'h00; X = 3'b000;

        drive("reset0", 1'b0, 1'b0, 8'hFF, 8'hFF, 3'b000);
        drive("reset1", 1'b0, 1'b0, 8'hFF, 8'hFF, 3'b000);
        drive("post_reset_add", 1'b1, 1'b0, 8'hFF, 8'hFF, 3'b000);

        drive("add_83_01", 1'b1, 1'b0, 8'b1000_0011, 8'h01, 3'b000);
        drive("add_wrap",  1'b1, 1'b0, 8'hFF, 8'h01, 3'b000);
        drive("sub_83_01", 1'b1, 1'b0, 8'b1000_0011, 8'h01, 3'b001);
        drive("sub_wrap",  1'b1, 1'b0, 8'h00, 8'h01, 3'b001);
        drive("sub_borrow_in", 1'b1, 1'b1, 8'h05, 8'h02, 3'b001);
        drive("and", 1'b1, 1'b0, 8'b1000_0011, 8'h01, 3'b010);
        drive("or",  1'b1, 1'b0, 8'b1000_0011, 8'h01, 3'b011);
        drive("not", 1'b1, 1'b1, 8'b1000_0011, 8'h55, 3'b100);
        drive("rsv5", 1'b1, 1'b1, 8'hA5, 8'h5A, 3'b101);
        drive("rsv6", 1'b1, 1'b0, 8'hFF, 8'hFF, 3'b110);
        drive("rsv7", 1'b1, 1'b1, 8'h7E, 8'h81, 3'b111);

        drive("add_before_rst", 1'b1, 1'b0, 8'hFF, 8'h01, 3'b000);
        drive("midstream_rst",  1'b0, 1'b1, 8'hFF, 8'hFF, 3'b000);
        drive("add_ovf", 1'b1, 1'b0, 8'h7F, 8'h01, 3'b000);
        drive("sub_zero", 1'b1, 1'b0, 8'h05, 8'h05, 3'b001);
        drive("sub_ovf", 1'b1, 1'b0, 8'h80, 8'h01, 3'b001);
        drive("add_cin_full", 1'b1, 1'b1, 8'hFF, 8'hFF, 3'b000);

        for (int i = 0; i < 300; i++) begin
            drive("random", ($urandom_range(0, 31) != 0), 1'($urandom),
                  8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
        end

        repeat (3) @(negedge CLK);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
